// File: rtl/aq_vfmau_pkg.sv
// Shared VFMAU definitions: stage limits, stage-index width and standard op latencies.
package aq_vfmau_pkg;

    localparam int AQ_VFMAU_STAGES_MAX = 8;
    localparam int AQ_VFMAU_IDX_W      = $clog2(AQ_VFMAU_STAGES_MAX);

    localparam logic [3:0] LAT_ADD     = 4'd2;
    localparam logic [3:0] LAT_MUL     = 4'd3;
    localparam logic [3:0] LAT_MAC_DBL = 4'd4;

    typedef logic [AQ_VFMAU_IDX_W-1:0] stage_idx_t;

endpackage

// File: rtl/aq_vfmau_pipe_ctrl_chk.sv
// Checks that no op ever sits in the last stage with latency still outstanding.
module aq_vfmau_pipe_ctrl_chk #(
    parameter int LAT_W = 4
) (
    input logic             clk,
    input logic             rst_b,
    input logic             vld_last,
    input logic [LAT_W-1:0] rem_last
);

    // Sampled each edge outside reset.
    always_ff @(posedge clk) begin
        if (rst_b) begin
            last_stage_rem_ok: assert (!(vld_last && (rem_last > LAT_W'(1))));
        end
    end

endmodule

// File: rtl/aq_vfmau_stage_slot.sv
// One execute-stage slot: live bit, remaining latency and tag, with load/hold/leave control.
module aq_vfmau_stage_slot #(
    parameter int LAT_W = 4,
    parameter int TAG_W = 6
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             flush,
    input  logic             load,
    input  logic [LAT_W-1:0] load_rem,
    input  logic [TAG_W-1:0] load_tag,
    input  logic             leave,
    output logic             vld,
    output logic [LAT_W-1:0] rem,
    output logic [TAG_W-1:0] tag
);

    // Slot state: a load wins over a leave so an op can enter as the previous one exits.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            vld <= 1'b0;
            rem <= {LAT_W{1'b0}};
            tag <= {TAG_W{1'b0}};
        end else if (flush) begin
            vld <= 1'b0;
        end else if (load) begin
            vld <= 1'b1;
            rem <= load_rem;
            tag <= load_tag;
        end else if (leave) begin
            vld <= 1'b0;
        end else begin
            vld <= vld;
        end
    end

endmodule

// File: rtl/aq_vfmau_pipe_ctrl.sv
// VFMAU pipeline controller: per-stage valid/latency tracking, oldest-first writeback
// arbitration, back-pressure stall chain and flush.
module aq_vfmau_pipe_ctrl
    import aq_vfmau_pkg::*;
#(
    parameter int STAGES = 4,
    parameter int LAT_W  = 4,
    parameter int TAG_W  = 6
) (
    input  logic                      cpuclk,
    input  logic                      cpurst_b,
    input  logic                      vpu_flush,
    input  logic                      issue_vld,
    output logic                      issue_rdy,
    input  logic [LAT_W-1:0]          issue_lat,
    input  logic [TAG_W-1:0]          issue_tag,
    input  logic [STAGES-1:0]         early_cmplt,
    input  logic [STAGES-1:0]         ext_stall,
    output logic [STAGES-1:0]         ctrl_dp_inst_vld,
    output logic [STAGES-1:0]         ctrl_dp_pipe_down,
    output logic [STAGES-1:0]         result_ready_nxt,
    output logic                      retire_vld,
    input  logic                      retire_rdy,
    output logic [AQ_VFMAU_IDX_W-1:0] retire_stage,
    output logic [TAG_W-1:0]          retire_tag
);

    logic [STAGES-1:0] vld;
    logic [LAT_W-1:0]  rem [STAGES];
    logic [TAG_W-1:0]  tag [STAGES];
    logic [STAGES-1:0] fin, pipe_down, leave, stall_int, load;
    logic [LAT_W-1:0]  load_rem [STAGES];
    logic [TAG_W-1:0]  load_tag [STAGES];
    logic [LAT_W-1:0]  issue_rem;
    stage_idx_t        win_idx;
    logic [TAG_W-1:0]  win_tag;
    logic              win_any, retire_go, issue_go, below_stall;

    // Finish detection and oldest-first (highest stage) writeback winner.
    always_comb begin
        fin     = {STAGES{1'b0}};
        win_idx = {AQ_VFMAU_IDX_W{1'b0}};
        win_tag = {TAG_W{1'b0}};
        win_any = 1'b0;
        for (int s = 0; s < STAGES; s++) begin
            fin[s] = vld[s] & ((rem[s] == LAT_W'(1)) | early_cmplt[s]);
            if (fin[s]) begin
                win_idx = AQ_VFMAU_IDX_W'(s);
                win_tag = tag[s];
                win_any = 1'b1;
            end else begin
                win_any = win_any;
            end
        end
        retire_vld   = win_any & ~vpu_flush;
        retire_go    = retire_vld & retire_rdy;
        retire_stage = retire_vld ? win_idx : {AQ_VFMAU_IDX_W{1'b0}};
        retire_tag   = retire_vld ? win_tag : {TAG_W{1'b0}};
    end

    // Stall chain resolved from the last stage back, so a stage vacated this cycle can refill.
    always_comb begin
        pipe_down   = {STAGES{1'b0}};
        leave       = {STAGES{1'b0}};
        stall_int   = {STAGES{1'b0}};
        below_stall = 1'b0;
        for (int s = STAGES - 1; s >= 0; s--) begin
            if (s == STAGES - 1) begin
                pipe_down[s] = 1'b0;
            end else begin
                pipe_down[s] = vld[s] & ~fin[s] & ~below_stall;
            end
            leave[s]     = pipe_down[s] | (retire_go & (win_idx == AQ_VFMAU_IDX_W'(s)));
            stall_int[s] = ext_stall[s] | (vld[s] & ~leave[s]);
            below_stall  = stall_int[s];
        end
        issue_rdy = ~stall_int[0] & ~vpu_flush;
        issue_go  = issue_vld & issue_rdy;
    end

    // Issue latency clamped into 1..STAGES.
    always_comb begin
        if (issue_lat == {LAT_W{1'b0}}) begin
            issue_rem = LAT_W'(1);
        end else if (issue_lat > LAT_W'(STAGES)) begin
            issue_rem = LAT_W'(STAGES);
        end else begin
            issue_rem = issue_lat;
        end
    end

    // Slot load sources: EX1 from issue, later stages from the stage above.
    always_comb begin
        load        = {STAGES{1'b0}};
        load[0]     = issue_go;
        load_rem[0] = issue_rem;
        load_tag[0] = issue_tag;
        for (int s = 1; s < STAGES; s++) begin
            load[s]     = pipe_down[s-1];
            load_rem[s] = rem[s-1] - LAT_W'(1);
            load_tag[s] = tag[s-1];
        end
    end

    for (genvar g = 0; g < STAGES; g++) begin : g_slot
        aq_vfmau_stage_slot #(.LAT_W(LAT_W), .TAG_W(TAG_W)) u_slot (
            .clk      (cpuclk),
            .rst_b    (cpurst_b),
            .flush    (vpu_flush),
            .load     (load[g]),
            .load_rem (load_rem[g]),
            .load_tag (load_tag[g]),
            .leave    (leave[g]),
            .vld      (vld[g]),
            .rem      (rem[g]),
            .tag      (tag[g])
        );
    end

    // Datapath hints straight from slot state.
    always_comb begin
        ctrl_dp_inst_vld  = vld;
        ctrl_dp_pipe_down = pipe_down;
        for (int s = 0; s < STAGES; s++) begin
            result_ready_nxt[s] = vld[s] & (rem[s] == LAT_W'(2)) & ~early_cmplt[s];
        end
    end

    aq_vfmau_pipe_ctrl_chk #(.LAT_W(LAT_W)) u_chk (
        .clk      (cpuclk),
        .rst_b    (cpurst_b),
        .vld_last (vld[STAGES-1]),
        .rem_last (rem[STAGES-1])
    );

endmodule

// File: tb/tb_aq_vfmau_pipe_ctrl.sv
// Randomised bench for aq_vfmau_pipe_ctrl against an op-level pipeline model.
module tb_aq_vfmau_pipe_ctrl;
    import aq_vfmau_pkg::*;

    localparam int S  = 4;
    localparam int LW = 4;
    localparam int TW = 6;

    logic          clk = 1'b0;
    logic          rst_b, flush, iv, rr;
    logic [LW-1:0] ilat;
    logic [TW-1:0] itag;
    logic [S-1:0]  early, es;
    logic          irdy, rvld;
    logic [S-1:0]  dvld, dpd, rrn;
    logic [2:0]    rstage;
    logic [TW-1:0] rtag;

    aq_vfmau_pipe_ctrl #(.STAGES(S), .LAT_W(LW), .TAG_W(TW)) dut (
        .cpuclk            (clk),
        .cpurst_b          (rst_b),
        .vpu_flush         (flush),
        .issue_vld         (iv),
        .issue_rdy         (irdy),
        .issue_lat         (ilat),
        .issue_tag         (itag),
        .early_cmplt       (early),
        .ext_stall         (es),
        .ctrl_dp_inst_vld  (dvld),
        .ctrl_dp_pipe_down (dpd),
        .result_ready_nxt  (rrn),
        .retire_vld        (rvld),
        .retire_rdy        (rr),
        .retire_stage      (rstage),
        .retire_tag        (rtag)
    );

    always #5 clk = ~clk;

    // Model: one entry per stage holding the op that occupies it.
    bit mv [S] = '{default: 1'b0};
    int mrem [S] = '{default: 0};
    int mtag [S] = '{default: 0};

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    logic [S-1:0] e_vld, e_pd, e_rrn;
    logic         e_rdy, e_rvld;
    logic [31:0]  e_stage, e_tag;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic idle();
        rst_b = 1'b1; flush = 1'b0; iv = 1'b0; ilat = '0; itag = '0;
        early = '0; es = '0; rr = 1'b1;
    endtask

    // Called just after a falling edge with inputs driven: predict, compare, then advance the model.
    task automatic tick();
        bit fin [S];
        bit mov [S];
        bit lv [S];
        bit nv [S];
        int nr [S];
        int nt [S];
        int win, cl;
        bit go, acc;
        #1;
        win = -1;
        for (int s = 0; s < S; s++) begin
            fin[s] = mv[s] && (mrem[s] == 1 || early[s]);
            if (fin[s]) win = s;
        end
        e_rvld = (win >= 0) && !flush;
        go     = e_rvld && rr;
        acc    = 1'b0;
        for (int s = S - 1; s >= 0; s--) begin
            mov[s] = (s < S - 1) && mv[s] && !fin[s] && acc;
            lv[s]  = mov[s] || (go && win == s);
            acc    = !es[s] && !(mv[s] && !lv[s]);
        end
        e_rdy   = acc && !flush;
        e_stage = e_rvld ? 32'(win) : 32'd0;
        e_tag   = (e_rvld && win >= 0) ? 32'(mtag[win]) : 32'd0;
        for (int s = 0; s < S; s++) begin
            e_vld[s] = mv[s];
            e_pd[s]  = mov[s];
            e_rrn[s] = mv[s] && mrem[s] == 2 && !early[s];
        end
        if (chk_en) begin
            check("issue_rdy",        32'(irdy),   32'(e_rdy));
            check("inst_vld",         32'(dvld),   32'(e_vld));
            check("pipe_down",        32'(dpd),    32'(e_pd));
            check("result_ready_nxt", 32'(rrn),    32'(e_rrn));
            check("retire_vld",       32'(rvld),   32'(e_rvld));
            check("retire_stage",     32'(rstage), e_stage);
            check("retire_tag",       32'(rtag),   e_tag);
        end
        @(posedge clk);
        if (!rst_b || flush) begin
            for (int s = 0; s < S; s++) mv[s] = 1'b0;
        end else begin
            cl = (ilat == 0) ? 1 : ((int'(ilat) > S) ? S : int'(ilat));
            for (int s = 0; s < S; s++) begin
                nv[s] = 1'b0; nr[s] = mrem[s]; nt[s] = mtag[s];
                if (s > 0) begin
                    if (mov[s-1]) begin
                        nv[s] = 1'b1; nr[s] = mrem[s-1] - 1; nt[s] = mtag[s-1];
                    end else if (mv[s] && !lv[s]) begin
                        nv[s] = 1'b1;
                    end
                end else if (iv && e_rdy) begin
                    nv[s] = 1'b1; nr[s] = cl; nt[s] = int'(itag);
                end else if (mv[s] && !lv[s]) begin
                    nv[s] = 1'b1;
                end
            end
            for (int s = 0; s < S; s++) begin
                mv[s] = nv[s]; mrem[s] = nr[s]; mtag[s] = nt[s];
            end
        end
    endtask

    task automatic issue_op(input int lat, input int t);
        @(negedge clk); idle(); iv = 1'b1; ilat = LW'(lat); itag = TW'(t); tick();
    endtask

    task automatic idle_tick();
        @(negedge clk); idle(); tick();
    endtask

    initial begin
        idle();
        rst_b = 1'b0;
        tick();
        chk_en = 1'b1;
        @(negedge clk); idle(); rst_b = 1'b0; tick();
        check("pin_reset_rdy", 32'(e_rdy), 32'd1);
        check("pin_reset_vld", 32'(e_vld), 32'd0);

        // Short op: ready hint in EX1, retire from EX2 one cycle after load.
        issue_op(int'(LAT_ADD), 5);
        check("pin_t1_accept", 32'(e_rdy), 32'd1);
        idle_tick();
        check("pin_t1_rrn", 32'(e_rrn), 32'h1);
        check("pin_t1_pd", 32'(e_pd), 32'h1);
        check("pin_t1_norv", 32'(e_rvld), 32'd0);
        idle_tick();
        check("pin_t1_rv", 32'(e_rvld), 32'd1);
        check("pin_t1_stage", e_stage, 32'd1);
        check("pin_t1_tag", e_tag, 32'd5);

        // Early completion in EX3 retires from stage 2 and nothing enters EX4.
        issue_op(int'(LAT_MAC_DBL), 9);
        idle_tick();
        idle_tick();
        @(negedge clk); idle(); early = 4'b0100; tick();
        check("pin_t4_rv", 32'(e_rvld), 32'd1);
        check("pin_t4_stage", e_stage, 32'd2);
        check("pin_t4_tag", e_tag, 32'd9);
        check("pin_t4_rrn", 32'(e_rrn), 32'd0);
        idle_tick();
        check("pin_t4_empty", 32'(e_vld), 32'd0);

        // Flush with three ops in flight, then immediate re-issue.
        issue_op(4, 1); issue_op(4, 2); issue_op(4, 3);
        @(negedge clk); idle(); flush = 1'b1; tick();
        check("pin_fl_rdy", 32'(e_rdy), 32'd0);
        check("pin_fl_rv", 32'(e_rvld), 32'd0);
        issue_op(3, 7);
        check("pin_fl_empty", 32'(e_vld), 32'd0);
        check("pin_fl_accept", 32'(e_rdy), 32'd1);
        idle_tick();
        check("pin_fl_reload", 32'(e_vld), 32'h1);

        // Reset with three ops in flight.
        issue_op(4, 11); issue_op(4, 12); issue_op(4, 13);
        @(negedge clk); idle(); rst_b = 1'b0; tick();
        issue_op(2, 14);
        check("pin_rst_empty", 32'(e_vld), 32'd0);
        check("pin_rst_rv", 32'(e_rvld), 32'd0);
        check("pin_rst_accept", 32'(e_rdy), 32'd1);

        // Held writeback with the pipe full.
        issue_op(4, 20); issue_op(3, 21); issue_op(2, 22); issue_op(4, 23);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); idle(); rr = 1'b0; tick();
        end
        for (int i = 0; i < 8; i++) idle_tick();
        check("pin_drain", 32'(e_vld), 32'd0);

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            idle();
            rst_b = ($urandom_range(0, 199) != 0);
            flush = ($urandom_range(0, 59) == 0);
            iv    = ($urandom_range(0, 9) < 7);
            ilat  = ($urandom_range(0, 19) == 0) ? LW'($urandom_range(0, 15)) : LW'($urandom_range(0, 5));
            itag  = TW'($urandom);
            rr    = ($urandom_range(0, 3) != 0);
            for (int s = 0; s < S; s++) begin
                early[s] = ($urandom_range(0, 15) == 0);
                es[s]    = ($urandom_range(0, 7) == 0);
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
